// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// cv32e40p_rf_recovery_ctrl: setback the core, then stream a shadow register file into it two registers per cycle
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   start_i                           recovery request, sampled only while idle
//   backup_raddr_a/b_o, rdata_a/b_i   shadow RF read ports (even / odd registers, 1-cycle read latency)
//   backup_hold_o                     freezes shadow RF updates while busy
//   setback_o, recover_o              core reset and recovery-mode controls
//   regfile_waddr/wdata/we_a/b_o      core RF recovery write ports
//   busy_o, done_o                    sequence active, one-cycle completion pulse
module cv32e40p_rf_recovery_ctrl #(
  parameter int NUM_REGS       = 32,
  parameter int SETBACK_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [5:0]  backup_raddr_a_o,
  output logic [5:0]  backup_raddr_b_o,
  input  logic [31:0] backup_rdata_a_i,
  input  logic [31:0] backup_rdata_b_i,
  output logic        backup_hold_o,
  output logic        setback_o,
  output logic        recover_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic        regfile_we_a_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_b_o,
  output logic        regfile_we_b_o,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, SETBACK, RESTORE, DRAIN, DONE} state_t;
  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS - 2);
  localparam logic [3:0] LAST_SB  = 4'(SETBACK_CYCLES - 1);
  state_t     state;
  logic [3:0] sb_cnt;
  logic       busy;
  logic       we;
  // Shadow read data arrives one cycle after its address, which lines up with the registered write address.
  assign regfile_wdata_a_o = backup_rdata_a_i;
  assign regfile_wdata_b_o = backup_rdata_b_i;
  assign regfile_we_a_o    = we;
  assign regfile_we_b_o    = we;
  assign busy_o            = busy;
  assign backup_hold_o     = busy;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      sb_cnt            <= 4'd0;
      busy              <= 1'b0;
      we                <= 1'b0;
      setback_o         <= 1'b0;
      recover_o         <= 1'b0;
      done_o            <= 1'b0;
      backup_raddr_a_o  <= 6'd0;
      backup_raddr_b_o  <= 6'd0;
      regfile_waddr_a_o <= 6'd0;
      regfile_waddr_b_o <= 6'd0;
    end else begin
      regfile_waddr_a_o <= backup_raddr_a_o;
      regfile_waddr_b_o <= backup_raddr_b_o;
      we                <= state == RESTORE;
      case (state)
        IDLE: if (start_i) begin
          state     <= SETBACK;
          sb_cnt    <= 4'd0;
          setback_o <= 1'b1;
          recover_o <= 1'b1;
          busy      <= 1'b1;
        end
        SETBACK: begin
          sb_cnt <= sb_cnt + 4'd1;
          if (sb_cnt == LAST_SB) begin
            state            <= RESTORE;
            setback_o        <= 1'b0;
            backup_raddr_a_o <= 6'd0;
            backup_raddr_b_o <= 6'd1;
          end
        end
        RESTORE: if (backup_raddr_a_o == LAST_IDX) state <= DRAIN;
        else begin
          backup_raddr_a_o <= backup_raddr_a_o + 6'd2;
          backup_raddr_b_o <= backup_raddr_b_o + 6'd2;
        end
        DRAIN: begin
          state     <= DONE;
          recover_o <= 1'b0;
          done_o    <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
